// File: rtl/tia_color_lum_registers_if.sv
// ============================================================================
// tia_color_lum_registers_if : pixel-side bus for the TIA colour/lum register bank
// Rev 1.0
// ============================================================================
`default_nettype none

interface tia_color_lum_registers_if;
  logic p0, m0, p1, m1, pf, bl;
  logic blank, cntd, score_bar, pfp_bar;
  logic d1, d2, d3, d4, d5, d6, d7;
  logic bkci, pfci, p1ci, p0ci;
  logic blk_bar;
  logic l0, l1, l2;
  logic c0, c1, c2, c3;

  modport master (
    output p0, m0, p1, m1, pf, bl, blank, cntd, score_bar, pfp_bar,
    output d1, d2, d3, d4, d5, d6, d7, bkci, pfci, p1ci, p0ci,
    input  blk_bar, l0, l1, l2, c0, c1, c2, c3
  );

  modport slave (
    input  p0, m0, p1, m1, pf, bl, blank, cntd, score_bar, pfp_bar,
    input  d1, d2, d3, d4, d5, d6, d7, bkci, pfci, p1ci, p0ci,
    output blk_bar, l0, l1, l2, c0, c1, c2, c3
  );
endinterface

`default_nettype wire

// File: rtl/tia_color_lum_registers.sv
// ============================================================================
// tia_color_lum_registers : colour/luminance registers and priority encoder
// Rev 1.0
// ============================================================================
`default_nettype none

module tia_color_lum_registers (
  input  wire logic               clkp,
  input  wire logic               rst_bar,
  tia_color_lum_registers_if.slave bus
);

  logic [6:0] bk_reg, pf_reg, p1_reg, p0_reg;
  logic [6:0] data_word;
  logic [6:0] sel_word;
  logic [6:0] out_reg;
  logic       blk_reg;
  logic       hit_p0, hit_p1;

  assign data_word = {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1};
  assign hit_p0    = bus.p0 | bus.m0;
  assign hit_p1    = bus.p1 | bus.m1;

  always_ff @(posedge clkp or negedge rst_bar) begin
    if (!rst_bar) begin
      bk_reg <= 7'd0;
      pf_reg <= 7'd0;
      p1_reg <= 7'd0;
      p0_reg <= 7'd0;
    end else begin
      if (bus.bkci) bk_reg <= data_word;
      if (bus.pfci) pf_reg <= data_word;
      if (bus.p1ci) p1_reg <= data_word;
      if (bus.p0ci) p0_reg <= data_word;
    end
  end

  // Score mode recolours only the playfield, using the player colour of the current screen half.
  always_comb begin
    sel_word = bk_reg;
    if (!bus.pfp_bar) begin
      if (bus.pf | bus.bl)  sel_word = pf_reg;
      else if (hit_p0)      sel_word = p0_reg;
      else if (hit_p1)      sel_word = p1_reg;
    end else begin
      if (hit_p0)           sel_word = p0_reg;
      else if (hit_p1)      sel_word = p1_reg;
      else if (bus.pf)      sel_word = bus.score_bar ? pf_reg : (bus.cntd ? p1_reg : p0_reg);
      else if (bus.bl)      sel_word = pf_reg;
    end
  end

  always_ff @(posedge clkp or negedge rst_bar) begin
    if (!rst_bar) begin
      out_reg <= 7'd0;
      blk_reg <= 1'b0;
    end else begin
      out_reg <= bus.blank ? 7'd0 : sel_word;
      blk_reg <= ~bus.blank;
    end
  end

  assign bus.blk_bar = blk_reg;
  assign bus.l0      = out_reg[0];
  assign bus.l1      = out_reg[1];
  assign bus.l2      = out_reg[2];
  assign bus.c0      = out_reg[3];
  assign bus.c1      = out_reg[4];
  assign bus.c2      = out_reg[5];
  assign bus.c3      = out_reg[6];

endmodule

`default_nettype wire

// File: tb/tb_tia_color_lum_registers.sv
// ============================================================================
// tb_tia_color_lum_registers : directed + random bench with a priority-list reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tia_color_lum_registers;

  logic clkp = 1'b0;
  logic rst_bar;
  always #5 clkp = ~clkp;

  tia_color_lum_registers_if bus ();

  tia_color_lum_registers dut (
    .clkp    (clkp),
    .rst_bar (rst_bar),
    .bus     (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference register file indexed 0=BK, 1=PF, 2=P1, 3=P0
  logic [6:0] mreg [4];
  logic [6:0] exp_o;
  logic       exp_blk;

  function automatic logic [6:0] got_o();
    return {bus.c3, bus.c2, bus.c1, bus.c0, bus.l2, bus.l1, bus.l0};
  endfunction

  function automatic logic [6:0] bus_data();
    return {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1};
  endfunction

  // Ordered list of colour claims; the first claim raised wins, background is the fallback.
  function automatic int pick();
    int hits[$];
    if (!bus.pfp_bar) begin
      if (bus.pf || bus.bl) hits.push_back(1);
      if (bus.p0 || bus.m0) hits.push_back(3);
      if (bus.p1 || bus.m1) hits.push_back(2);
    end else begin
      if (bus.p0 || bus.m0) hits.push_back(3);
      if (bus.p1 || bus.m1) hits.push_back(2);
      if (bus.pf)           hits.push_back(bus.score_bar ? 1 : (bus.cntd ? 2 : 3));
      if (bus.bl)           hits.push_back(1);
    end
    hits.push_back(0);
    return hits[0];
  endfunction

  // obj = {p0, m0, p1, m1, pf, bl}
  task automatic drive(input logic [5:0] obj, input logic blank, input logic cntd,
                       input logic score_bar, input logic pfp_bar);
    {bus.p0, bus.m0, bus.p1, bus.m1, bus.pf, bus.bl} = obj;
    bus.blank     = blank;
    bus.cntd      = cntd;
    bus.score_bar = score_bar;
    bus.pfp_bar   = pfp_bar;
  endtask

  // stb = {bkci, pfci, p1ci, p0ci}
  task automatic set_data(input logic [6:0] v, input logic [3:0] stb);
    {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1} = v;
    {bus.bkci, bus.pfci, bus.p1ci, bus.p0ci} = stb;
  endtask

  task automatic check_model(input string tag);
    n_assert++;
    assert (got_o() === exp_o) else begin
      n_fail++;
      $error("FAIL %s o=%b expected %b", tag, got_o(), exp_o);
    end
    n_assert++;
    assert (bus.blk_bar === exp_blk) else begin
      n_fail++;
      $error("FAIL %s_blk blk_bar=%b expected %b", tag, bus.blk_bar, exp_blk);
    end
  endtask

  // One clock: model samples at the edge, DUT checked on the falling edge; want<0 skips the constant check.
  task automatic tick(input string tag, input int want);
    logic [6:0] w;
    @(posedge clkp);
    exp_blk = !bus.blank;
    exp_o   = bus.blank ? 7'd0 : mreg[pick()];
    if (bus.bkci) mreg[0] = bus_data();
    if (bus.pfci) mreg[1] = bus_data();
    if (bus.p1ci) mreg[2] = bus_data();
    if (bus.p0ci) mreg[3] = bus_data();
    @(negedge clkp);
    check_model(tag);
    if (want >= 0) begin
      w = want[6:0];
      n_assert++;
      assert (got_o() === w) else begin
        n_fail++;
        $error("FAIL %s_const o=%b expected %b", tag, got_o(), w);
      end
    end
  endtask

  logic [5:0] norm_obj [7] = '{6'b111111, 6'b011111, 6'b001111, 6'b000111, 6'b000011, 6'b000001, 6'b000000};
  logic [6:0] norm_exp [7] = '{7'b1010101, 7'b1010101, 7'b0101010, 7'b0101010, 7'b1111111, 7'b1111111, 7'b1110000};
  logic [5:0] pfp_obj  [7] = '{6'b111111, 6'b111110, 6'b111100, 6'b101100, 6'b001100, 6'b001000, 6'b000000};
  logic [6:0] pfp_exp  [7] = '{7'b1111111, 7'b1111111, 7'b1010101, 7'b1010101, 7'b0101010, 7'b0101010, 7'b1110000};

  initial begin
    rst_bar = 1'b0;
    drive(6'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    set_data(7'd0, 4'b0000);
    foreach (mreg[i]) mreg[i] = 7'd0;
    exp_o = 7'd0; exp_blk = 1'b0;
    repeat (3) @(negedge clkp);
    check_model("reset");

    rst_bar = 1'b1;
    set_data(7'b1110000, 4'b1000); tick("ld_bk", -1);
    set_data(7'b1111111, 4'b0100); tick("ld_pf", 7'b1110000);
    set_data(7'b0101010, 4'b0010); tick("ld_p1", 7'b1110000);
    set_data(7'b1010101, 4'b0001); tick("ld_p0", 7'b1110000);
    set_data(7'b0000000, 4'b0000);
    tick("idle_bk", 7'b1110000);
    drive(6'b100000, 0, 0, 1, 1); tick("p0", 7'b1010101);
    drive(6'b001000, 0, 0, 1, 1); tick("p1", 7'b0101010);
    drive(6'b000010, 0, 0, 1, 1); tick("pf", 7'b1111111);
    drive(6'b000100, 0, 0, 1, 1); tick("m1", 7'b0101010);
    drive(6'b010000, 0, 0, 1, 1); tick("m0", 7'b1010101);
    drive(6'b000001, 0, 0, 1, 1); tick("bl", 7'b1111111);

    for (int i = 0; i < 7; i++) begin
      drive(norm_obj[i], 0, 0, 1, 1); tick("norm_prio", int'(norm_exp[i]));
    end
    for (int i = 0; i < 7; i++) begin
      drive(pfp_obj[i], 0, 0, 1, 0); tick("pf_prio", int'(pfp_exp[i]));
    end

    drive(6'b000010, 0, 0, 0, 1); tick("score_left", 7'b1010101);
    drive(6'b000010, 0, 1, 0, 1); tick("score_right", 7'b0101010);
    drive(6'b001010, 0, 1, 0, 1); tick("score_p1", 7'b0101010);
    drive(6'b101010, 0, 1, 0, 1); tick("score_p0", 7'b1010101);
    drive(6'b000001, 0, 1, 0, 1); tick("score_bl", 7'b1111111);

    drive(6'b111111, 1, 0, 1, 1); tick("blank", 7'b0000000);
    drive(6'b111111, 0, 0, 1, 1); tick("unblank", 7'b1010101);

    // Same-cycle write and select of P0 must still show the old value.
    drive(6'b100000, 0, 0, 1, 1); set_data(7'b0011001, 4'b0001); tick("wr_same", 7'b1010101);
    set_data(7'd0, 4'b0000); tick("wr_next", 7'b0011001);

    #2 rst_bar = 1'b0;
    foreach (mreg[i]) mreg[i] = 7'd0;
    exp_o = 7'd0; exp_blk = 1'b0;
    #1 check_model("async_rst");
    @(posedge clkp); @(negedge clkp);
    check_model("rst_hold");
    rst_bar = 1'b1;
    drive(6'b000000, 0, 0, 1, 1);
    tick("post_rst", 7'b0000000);
    tick("post_rst2", 7'b0000000);

    for (int i = 0; i < 400; i++) begin
      drive(6'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
      set_data(7'($urandom), {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)});
      tick("random", -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tia_color_lum_registers.md
# tia_color_lum_registers

Colour/luminance register bank and priority encoder for the TIA video path. Holds the four 7-bit colour registers (background, playfield, player 1, player 0), loaded from the data bus by write strobes. Each pixel clock it selects one register from the object coincidence signals, priority control and score mode, and drives the selected 3-bit luminance and 4-bit hue to the video output stage. Sits between the object/playfield generators and the analog output logic.

## Interface
- No parameters.
- clkp  in  1  pixel clock; all state updates on rising edge.
- rst_bar  in  1  asynchronous active-low reset.
- p0, m0, p1, m1, pf, bl  in  1 each  object coincidence for the current pixel: player 0, missile 0, player 1, missile 1, playfield, ball.
- blank  in  1  blanking request; forces black output.
- cntd  in  1  screen-half indicator for score mode: 0 = left half, 1 = right half.
- score_bar  in  1  active-low score mode (CTRLPF D1).
- pfp_bar  in  1  active-low playfield priority (CTRLPF D2).
- d1..d7  in  1 each  data bus bits D1..D7 (D0 not used).
- bkci, pfci, p1ci, p0ci  in  1 each  write strobes for COLUBK, COLUPF, COLUP1, COLUP0.
- blk_bar  out  1  registered active-low blank indication.
- l0, l1, l2  out  1 each  luminance bits, from register bits D1..D3.
- c0, c1, c2, c3  out  1 each  hue bits, from register bits D4..D7.

## Operation
- Four 7-bit registers BK, PF, P1, P0, each storing {d7..d1}.
- Register write: on rising clkp with its strobe high, the register loads d7..d1. Strobes are independent; multiple strobes high in one cycle load all selected registers with the same value.
- Output word o = {c3,c2,c1,c0,l2,l1,l0} = selected register {D7..D1}.
- Selection, normal priority (pfp_bar=1):
  - p0 or m0 -> P0.
  - else p1 or m1 -> P1.
  - else pf -> PF, except in score mode (score_bar=0): pf with cntd=0 -> P0, pf with cntd=1 -> P1.
  - else bl -> PF (score mode does not affect the ball).
  - else -> BK.
- Selection, playfield priority (pfp_bar=0):
  - pf or bl -> PF (score mode ignored).
  - else p0 or m0 -> P0.
  - else p1 or m1 -> P1.
  - else -> BK.
- blank=1 overrides all selection: o = 0000000, blk_bar = 0. blank=0: blk_bar = 1.

## Timing
- Reset (rst_bar=0, asynchronous): all four registers = 0, o = 0000000, blk_bar = 0. Held while rst_bar low; release takes effect at the next rising clkp.
- Output register: on each rising clkp, o and blk_bar capture the selection result computed from the object, control and blank inputs present before that edge and from the register contents before that edge. Latency is one clkp cycle from input to output.
- A register write and a selection of the same register in the same cycle: output shows the old value; the new value appears from the next edge.
- Inputs change only between rising edges; no combinational path from inputs to outputs.

## Test plan
- Load BK=1110000, PF=1111111, P1=0101010, P0=1010101 (one strobe per cycle); all objects low -> o=1110000, blk_bar=1. Then p0 alone -> 1010101; p1 -> 0101010; pf -> 1111111; m1 -> 0101010; m0 -> 1010101; bl -> 1111111.
- Normal priority: all six objects high, then drop p0, m0, p1, m1, pf, bl one per cycle -> 1010101, 1010101, 0101010, 0101010, 1111111, 1111111, then 1110000.
- pfp_bar=0, all objects high, then drop bl, pf, m0, p0, m1, p1 one per cycle -> 1111111, 1111111, 1010101, 1010101, 0101010, 0101010, then 1110000.
- score_bar=0, pfp_bar=1: pf with cntd=0 -> 1010101; cntd=1 -> 0101010; add p1 -> 0101010; add p0 -> 1010101; bl alone -> 1111111.
- blank=1 with any objects -> o=0000000, blk_bar=0 one cycle later; blank=0 restores selection and blk_bar=1.
- Assert rst_bar=0 mid-operation -> o=0000000, blk_bar=0 immediately. After release with all objects low and blank=0 -> o=0000000 (BK cleared) until registers are reloaded.
